// File: rtl/usr_frame_sequencer.sv
// usr_frame_sequencer: control stage in front of a universal shift register.
// Accepts a parallel word on a valid/ready handshake, loads it into the USR,
// then shifts it out LSB-first or MSB-first with a valid qualifier on the
// serial bit, followed by an optional idle gap.
module usr_frame_sequencer #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             fill,
    input  logic             pause,
    input  logic [WIDTH-1:0] usr_q,
    output logic             S1,
    output logic             S0,
    output logic [WIDTH-1:0] I,
    output logic             MSB_in,
    output logic             LSB_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        GAP   = 2'b11
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic [GW-1:0]     gcnt, gcnt_nxt;
    logic [WIDTH-1:0]  dreg;
    logic              dir;
    logic              accept;
    logic              frame_done_nxt;

    // State, counters and the captured word/direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            gcnt       <= '0;
            dreg       <= '0;
            dir        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            state      <= state_nxt;
            count      <= count_nxt;
            gcnt       <= gcnt_nxt;
            frame_done <= frame_done_nxt;
            if (accept) begin
                dreg <= in_data;
                dir  <= in_dir;
            end
        end
    end

    // Next-state logic and Moore decode of the USR drive; only usr_q and pause
    // (plus fill into the serial inputs) reach the outputs combinationally.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves a variable unassigned, which would infer a latch.
        state_nxt      = state;
        count_nxt      = count;
        gcnt_nxt       = gcnt;
        frame_done_nxt = 1'b0;
        accept         = 1'b0;
        in_ready       = 1'b0;
        S1             = 1'b0;
        S0             = 1'b0;
        I              = '0;
        MSB_in         = 1'b0;
        LSB_in         = 1'b0;
        ser_out        = 1'b0;
        ser_valid      = 1'b0;
        busy           = (state != IDLE);

        case (state)
            IDLE: begin
                // Held low while reset is asserted so no source sees a ready.
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                S1        = 1'b1;
                S0        = 1'b1;
                I         = dreg;
                count_nxt = '0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                ser_out = dir ? usr_q[WIDTH-1] : usr_q[0];
                if (dir) LSB_in = fill;
                else     MSB_in = fill;
                if (!pause) begin
                    S1        = dir;
                    S0        = ~dir;
                    ser_valid = 1'b1;
                    if (count == COUNT_LAST) begin
                        count_nxt      = '0;
                        frame_done_nxt = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            gcnt_nxt  = '0;
                            state_nxt = GAP;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        count_nxt = count + CW'(1);
                    end
                end
            end
            GAP: begin
                if (gcnt == GAP_LAST) state_nxt = IDLE;
                else                  gcnt_nxt  = gcnt + GW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_usr_frame_sequencer.sv
// Testbench for usr_frame_sequencer: two instances (gap 1 and gap 0), each
// driving a behavioural 4-bit universal shift register fed back into usr_q.
module tb_usr_frame_sequencer;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Instance A: GAP_CYCLES = 1
    logic         a_in_valid = 1'b0, a_in_ready;
    logic [W-1:0] a_in_data = '0;
    logic         a_in_dir = 1'b0, a_fill = 1'b0, a_pause = 1'b0;
    logic [W-1:0] a_usr_q = '0;
    logic         a_s1, a_s0, a_msb_in, a_lsb_in, a_ser_out, a_ser_valid, a_busy, a_frame_done;
    logic [W-1:0] a_i;

    // Instance B: GAP_CYCLES = 0
    logic         b_in_valid = 1'b0, b_in_ready;
    logic [W-1:0] b_in_data = '0;
    logic         b_in_dir = 1'b0, b_fill = 1'b0, b_pause = 1'b0;
    logic [W-1:0] b_usr_q = '0;
    logic         b_s1, b_s0, b_msb_in, b_lsb_in, b_ser_out, b_ser_valid, b_busy, b_frame_done;
    logic [W-1:0] b_i;

    usr_frame_sequencer #(.WIDTH(W), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_dir(a_in_dir), .fill(a_fill), .pause(a_pause),
        .usr_q(a_usr_q), .S1(a_s1), .S0(a_s0), .I(a_i), .MSB_in(a_msb_in),
        .LSB_in(a_lsb_in), .ser_out(a_ser_out), .ser_valid(a_ser_valid),
        .busy(a_busy), .frame_done(a_frame_done)
    );

    usr_frame_sequencer #(.WIDTH(W), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_dir(b_in_dir), .fill(b_fill), .pause(b_pause),
        .usr_q(b_usr_q), .S1(b_s1), .S0(b_s0), .I(b_i), .MSB_in(b_msb_in),
        .LSB_in(b_lsb_in), .ser_out(b_ser_out), .ser_valid(b_ser_valid),
        .busy(b_busy), .frame_done(b_frame_done)
    );

    // Universal shift register models (no reset: Q only changes on S modes).
    always @(posedge clk) begin
        case ({a_s1, a_s0})
            2'b01:   a_usr_q <= {a_msb_in, a_usr_q[W-1:1]};
            2'b10:   a_usr_q <= {a_usr_q[W-2:0], a_lsb_in};
            2'b11:   a_usr_q <= a_i;
            default: a_usr_q <= a_usr_q;
        endcase
    end

    always @(posedge clk) begin
        case ({b_s1, b_s0})
            2'b01:   b_usr_q <= {b_msb_in, b_usr_q[W-1:1]};
            2'b10:   b_usr_q <= {b_usr_q[W-2:0], b_lsb_in};
            2'b11:   b_usr_q <= b_i;
            default: b_usr_q <= b_usr_q;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One cycle of stimulus and the outputs expected during that same cycle.
    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         dir;
        logic         fill;
        logic         pause;
        logic [1:0]   s;
        logic [W-1:0] i;
        logic         ser;
        logic         sv;
        logic         rdy;
        logic         busy;
        logic         fd;
        logic [W-1:0] q;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    logic       bits [$];
    int         idx  [$];
    int         acc;
    int         fd_cnt;
    logic       hs;
    logic [7:0] exp_stream;

    initial begin
        //            v     d        dir   fill  pause   s      i        ser   sv    rdy   busy  fd    q
        // 1011, LSB first, fill 0 (data/dir changed mid-frame, ignored)
        vecs[0]  = '{1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[1]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b11, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011};
        vecs[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0101};
        vecs[4]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010};
        vecs[5]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001};
        vecs[6]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000};
        // 1011, MSB first, fill 1; in_valid held during the frame is ignored
        vecs[7]  = '{1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[8]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b11, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[9]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b10, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011};
        vecs[10] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0111};
        vecs[11] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b10, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111};
        vecs[12] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b10, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111};
        vecs[13] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111};
        // 0110, LSB first, 3-cycle pause after the 2nd shift; pause in LOAD/GAP/IDLE inert
        vecs[14] = '{1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111};
        vecs[15] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b11, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111};
        vecs[16] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110};
        vecs[17] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0011};
        vecs[18] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001};
        vecs[19] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001};
        vecs[20] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001};
        vecs[21] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001};
        vecs[22] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[23] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000};
        vecs[24] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};

        // Reset state while rst_n is low
        #1;
        check("rst a in_ready", 32'(a_in_ready), 32'd0);
        check("rst a S",        32'({a_s1, a_s0}), 32'd0);
        check("rst a I",        32'(a_i), 32'd0);
        check("rst a busy",     32'(a_busy), 32'd0);
        check("rst a frame_done", 32'(a_frame_done), 32'd0);
        check("rst b in_ready", 32'(b_in_ready), 32'd0);
        check("rst b S",        32'({b_s1, b_s0}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven frames on instance A
        for (int n = 0; n < NV; n++) begin
            @(posedge clk);
            #1;
            a_in_valid = vecs[n].v;
            a_in_data  = vecs[n].d;
            a_in_dir   = vecs[n].dir;
            a_fill     = vecs[n].fill;
            a_pause    = vecs[n].pause;
            @(negedge clk);
            check($sformatf("row%0d S", n),          32'({a_s1, a_s0}), 32'(vecs[n].s));
            check($sformatf("row%0d I", n),          32'(a_i), 32'(vecs[n].i));
            check($sformatf("row%0d ser_valid", n),  32'(a_ser_valid), 32'(vecs[n].sv));
            if (vecs[n].sv)
                check($sformatf("row%0d ser_out", n), 32'(a_ser_out), 32'(vecs[n].ser));
            check($sformatf("row%0d in_ready", n),   32'(a_in_ready), 32'(vecs[n].rdy));
            check($sformatf("row%0d busy", n),       32'(a_busy), 32'(vecs[n].busy));
            check($sformatf("row%0d frame_done", n), 32'(a_frame_done), 32'(vecs[n].fd));
            check($sformatf("row%0d usr_q", n),      32'(a_usr_q), 32'(vecs[n].q));
        end

        // Back-to-back 4'hA then 4'h5 on instance B (no gap), in_valid held high
        @(posedge clk);
        #1;
        b_in_valid = 1'b1;
        b_in_data  = 4'hA;
        acc    = 0;
        fd_cnt = 0;
        for (int c = 0; c < 40 && bits.size() < 8; c++) begin
            @(negedge clk);
            if (b_ser_valid) begin
                bits.push_back(b_ser_out);
                idx.push_back(c);
            end
            if (b_frame_done) fd_cnt++;
            hs = b_in_valid && b_in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                acc++;
                if (acc == 1) b_in_data  = 4'h5;
                else          b_in_valid = 1'b0;
            end
        end
        check("b2b bit count", 32'(bits.size()), 32'd8);
        if (bits.size() == 8) begin
            exp_stream = 8'b01011010;   // first bit in the MSB position
            for (int k = 0; k < 8; k++)
                check($sformatf("b2b bit%0d", k), 32'(bits[k]), 32'(exp_stream[7-k]));
            check("b2b first frame span", 32'(idx[3] - idx[0]), 32'd3);
            check("b2b inter-frame spacing", 32'(idx[4] - idx[3]), 32'd3);
        end
        check("b2b accepts", 32'(acc), 32'd2);
        check("b2b frame_done first", 32'(fd_cnt), 32'd1);
        @(negedge clk);
        check("b2b frame_done second", 32'(b_frame_done), 32'd1);
        check("b2b in_ready after", 32'(b_in_ready), 32'd1);
        check("b2b final usr_q", 32'(b_usr_q), 32'd0);

        // Reset during the 3rd shift of 1011 on instance A
        @(posedge clk);
        #1;
        a_in_valid = 1'b1;
        a_in_data  = 4'b1011;
        a_in_dir   = 1'b0;
        a_fill     = 1'b0;
        a_pause    = 1'b0;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort pre S", 32'({a_s1, a_s0}), 32'd1);
        check("abort pre usr_q", 32'(a_usr_q), 32'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort S",        32'({a_s1, a_s0}), 32'd0);
        check("abort busy",     32'(a_busy), 32'd0);
        check("abort I",        32'(a_i), 32'd0);
        check("abort in_ready", 32'(a_in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release in_ready", 32'(a_in_ready), 32'd1);

        // Idle with in_valid low after reset: nothing moves
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("idle%0d S", c),          32'({a_s1, a_s0}), 32'd0);
            check($sformatf("idle%0d busy", c),       32'(a_busy), 32'd0);
            check($sformatf("idle%0d frame_done", c), 32'(a_frame_done), 32'd0);
            check($sformatf("idle%0d usr_q", c),      32'(a_usr_q), 32'b0010);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
